// File: rtl/clap_sample_logger.sv
// ============================================================================
// clap_sample_logger: packs 8-bit samples into 32-bit SRAM words, serves reads
// Rev 1.0
// ============================================================================
`default_nettype none

module clap_sample_logger #(
  parameter int CAP_WORDS  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  done,
  output logic [8:0]            words,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  csb0,
  output logic                  web0,
  output logic [3:0]            wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [31:0]           din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           dout1
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [8:0] C_CAP_WORDS = 9'(CAP_WORDS);

  state_t                  state_q;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             pack_q, pack_d;
  logic [8:0]              words_q;
  logic                    s_ready_q, done_q;
  logic                    csb0_q, web0_q;
  logic [3:0]              wmask0_q;
  logic [ADDR_WIDTH-1:0]   addr0_q;
  logic [31:0]             din0_q;
  logic                    csb1_q;
  logic [ADDR_WIDTH-1:0]   addr1_q;
  logic                    rd_p2_q, rd_valid_q;
  logic [31:0]             rd_data_q;
  logic                    accept, word_full, last_word;
  logic [3:0]              part_mask;
  logic [8:0]              words_inc;

  assign accept    = s_valid && s_ready_q;
  assign word_full = accept && (lane_q == 2'd3);
  assign words_inc = words_q + 9'd1;
  assign last_word = word_full && (words_inc == C_CAP_WORDS);

  always_comb begin
    pack_d = pack_q;
    lane_d = lane_q;
    if (accept) begin
      pack_d[{lane_q, 3'b000} +: 8] = s_data;
      lane_d = lane_q + 2'd1;
    end
  end

  // Byte mask for a partial word: one bit per lane already filled.
  always_comb begin
    part_mask = 4'b0000;
    case (lane_q)
      2'd1:    part_mask = 4'b0001;
      2'd2:    part_mask = 4'b0011;
      2'd3:    part_mask = 4'b0111;
      default: part_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'd0;
      pack_q     <= 32'd0;
      words_q    <= 9'd0;
      s_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      wmask0_q   <= 4'd0;
      addr0_q    <= '0;
      din0_q     <= 32'd0;
      csb1_q     <= 1'b1;
      addr1_q    <= '0;
      rd_p2_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
    end else begin
      csb0_q <= 1'b1;
      web0_q <= 1'b1;

      // Read pipeline: request -> SRAM select -> SRAM data -> captured word.
      csb1_q     <= ~rd_req;
      if (rd_req) addr1_q <= rd_addr;
      rd_p2_q    <= ~csb1_q;
      rd_valid_q <= rd_p2_q;
      if (rd_p2_q) rd_data_q <= dout1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_CAPTURE;
            s_ready_q <= 1'b1;
            done_q    <= 1'b0;
            words_q   <= 9'd0;
            lane_q    <= 2'd0;
            pack_q    <= 32'd0;
          end
        end
        S_CAPTURE: begin
          pack_q <= pack_d;
          lane_q <= lane_d;
          if (word_full) begin
            csb0_q   <= 1'b0;
            web0_q   <= 1'b0;
            wmask0_q <= 4'b1111;
            addr0_q  <= ADDR_WIDTH'(words_q);
            din0_q   <= pack_d;
            words_q  <= words_inc;
            pack_q   <= 32'd0;
          end
          // Auto stop reuses FLUSH; the lane has wrapped to 0 so no write follows.
          if (last_word || stop) begin
            state_q   <= S_FLUSH;
            s_ready_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (lane_q != 2'd0) begin
            csb0_q   <= 1'b0;
            web0_q   <= 1'b0;
            wmask0_q <= part_mask;
            addr0_q  <= ADDR_WIDTH'(words_q);
            din0_q   <= pack_q;
            words_q  <= words_inc;
            lane_q   <= 2'd0;
            pack_q   <= 32'd0;
          end
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign done     = done_q;
  assign words    = words_q;
  assign csb0     = csb0_q;
  assign web0     = web0_q;
  assign wmask0   = wmask0_q;
  assign addr0    = addr0_q;
  assign din0     = din0_q;
  assign csb1     = csb1_q;
  assign addr1    = addr1_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_clap_sample_logger.sv
// ============================================================================
// tb_clap_sample_logger: directed bench with a behavioural dual-port SRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clap_sample_logger;

  localparam int CAP = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, s_valid, s_ready, done, rd_req, rd_valid;
  logic [7:0]    s_data;
  logic [8:0]    words;
  logic [AW-1:0] rd_addr, addr0, addr1;
  logic [31:0]   rd_data, din0, dout1;
  logic          csb0, web0, csb1;
  logic [3:0]    wmask0;

  int n_checks = 0;
  int n_errors = 0;

  clap_sample_logger #(.CAP_WORDS(CAP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .done(done), .words(words),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: inputs sampled on rising edge, write committed on falling edge.
  logic [31:0]   mem [0:255];
  logic          w_pend = 1'b0;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic [3:0]    w_mask;
  logic [43:0]   wq [$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    dout1 = 32'd0;
  end

  always @(posedge clk) begin
    if (!csb1) dout1 <= mem[addr1];
    w_pend <= !csb0 && !web0;
    w_addr <= addr0;
    w_data <= din0;
    w_mask <= wmask0;
  end

  always @(negedge clk) begin
    if (w_pend)
      for (int b = 0; b < 4; b++)
        if (w_mask[b]) mem[w_addr][b*8 +: 8] = w_data[b*8 +: 8];
    if (!csb0 && !web0) wq.push_back({wmask0, addr0, din0});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [43:0] e;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    rd_req = 1'b0; rd_addr = '0;
    tick(); tick();

    // Reset values
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    check("rst_csb0", 32'(csb0), 32'd1);
    check("rst_web0", 32'(web0), 32'd1);
    check("rst_csb1", 32'(csb1), 32'd1);
    check("rst_wmask0", 32'(wmask0), 32'd0);
    check("rst_din0", din0, 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full-word write
    start = 1'b1; tick(); start = 1'b0;
    check("cap_s_ready", 32'(s_ready), 32'd1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    s_valid = 1'b0;
    check("full_csb0", 32'(csb0), 32'd0);
    check("full_web0", 32'(web0), 32'd0);
    check("full_addr0", 32'(addr0), 32'd0);
    check("full_din0", din0, 32'h44332211);
    check("full_wmask0", 32'(wmask0), 32'hF);
    check("full_words", 32'(words), 32'd1);
    tick();
    check("full_csb0_off", 32'(csb0), 32'd1);

    // Single readback
    rd_req = 1'b1; rd_addr = 8'd0; tick(); rd_req = 1'b0;
    check("rd_csb1", 32'(csb1), 32'd0);
    check("rd_addr1", 32'(addr1), 32'd0);
    tick();
    check("rd_valid_t2", 32'(rd_valid), 32'd0);
    tick();
    check("rd_valid_t3", 32'(rd_valid), 32'd1);
    check("rd_data_t3", rd_data, 32'h44332211);
    tick();
    check("rd_valid_t4", 32'(rd_valid), 32'd0);
    check("rd_csb1_idle", 32'(csb1), 32'd1);

    // Second word, then back-to-back readback of addresses 0 and 1
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    s_valid = 1'b0;
    check("w1_addr0", 32'(addr0), 32'd1);
    check("w1_din0", din0, 32'h88776655);
    check("w1_words", 32'(words), 32'd2);
    rd_req = 1'b1; rd_addr = 8'd0; tick();
    rd_addr = 8'd1; tick();
    rd_req = 1'b0; tick();
    check("b2b_valid0", 32'(rd_valid), 32'd1);
    check("b2b_data0", rd_data, 32'h44332211);
    tick();
    check("b2b_valid1", 32'(rd_valid), 32'd1);
    check("b2b_data1", rd_data, 32'h88776655);
    tick();
    check("b2b_valid_end", 32'(rd_valid), 32'd0);

    // start during CAPTURE is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("ign_start_words", 32'(words), 32'd2);
    check("ign_start_ready", 32'(s_ready), 32'd1);

    // stop together with the 4th byte: full write, no flush write
    send(8'h01); send(8'h02); send(8'h03);
    s_data = 8'h04; s_valid = 1'b1; stop = 1'b1; tick();
    s_valid = 1'b0; stop = 1'b0;
    check("stop4_csb0", 32'(csb0), 32'd0);
    check("stop4_addr0", 32'(addr0), 32'd2);
    check("stop4_din0", din0, 32'h04030201);
    check("stop4_wmask0", 32'(wmask0), 32'hF);
    check("stop4_ready", 32'(s_ready), 32'd0);
    tick();
    check("stop4_noflush", 32'(csb0), 32'd1);
    check("stop4_done", 32'(done), 32'd1);
    check("stop4_words", 32'(words), 32'd3);

    // Partial flush
    wq.delete();
    start = 1'b1; tick(); start = 1'b0;
    check("pf_done_clr", 32'(done), 32'd0);
    check("pf_words_clr", 32'(words), 32'd0);
    send(8'hAA); send(8'hBB);
    s_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    check("pf_done_t1", 32'(done), 32'd0);
    tick();
    check("pf_done_t2", 32'(done), 32'd1);
    check("pf_words", 32'(words), 32'd1);
    tick();
    check("pf_nwrites", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      e = wq[0];
      check("pf_addr", 32'(e[39:32]), 32'd0);
      check("pf_data", 32'(e[15:0]), 32'h0000BBAA);
      check("pf_mask", 32'(e[43:40]), 32'h3);
    end

    // Auto stop after CAP words
    wq.delete();
    start = 1'b1; tick(); start = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_data = 8'(i + 1); s_valid = 1'b1;
      if (s_ready) acc++;
      tick();
    end
    s_valid = 1'b0;
    tick();
    check("as_accepted", 32'(acc), 32'd16);
    check("as_ready", 32'(s_ready), 32'd0);
    check("as_done", 32'(done), 32'd1);
    check("as_words", 32'(words), 32'd4);
    check("as_nwrites", wq.size(), 32'd4);
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      e = wq[k];
      check("as_addr", 32'(e[39:32]), 32'(k));
      check("as_data", e[31:0], {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
      check("as_mask", 32'(e[43:40]), 32'hF);
    end
    rd_req = 1'b1; rd_addr = 8'd3; tick(); rd_req = 1'b0;
    tick(); tick();
    check("as_rd_valid", 32'(rd_valid), 32'd1);
    check("as_rd_data", rd_data, 32'h100F0E0D);

    // Reset mid-capture with a read in flight
    start = 1'b1; tick(); start = 1'b0;
    send(8'hA1); send(8'hA2); send(8'hA3);
    rd_req = 1'b1; rd_addr = 8'd0;
    send(8'hA4);
    s_valid = 1'b0; rd_req = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wq.delete();
    check("mr_csb0", 32'(csb0), 32'd1);
    check("mr_web0", 32'(web0), 32'd1);
    check("mr_csb1", 32'(csb1), 32'd1);
    check("mr_words", 32'(words), 32'd0);
    check("mr_ready", 32'(s_ready), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_addr0", 32'(addr0), 32'd0);
    check("mr_din0", din0, 32'd0);
    check("mr_wmask0", 32'(wmask0), 32'd0);
    check("mr_rd_valid0", 32'(rd_valid), 32'd0);
    tick();
    check("mr_rd_valid1", 32'(rd_valid), 32'd0);
    tick();
    check("mr_rd_valid2", 32'(rd_valid), 32'd0);
    check("mr_nwrites", wq.size(), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4);
    s_valid = 1'b0;
    check("mr2_csb0", 32'(csb0), 32'd0);
    check("mr2_addr0", 32'(addr0), 32'd0);
    check("mr2_din0", din0, 32'hB4B3B2B1);
    check("mr2_words", 32'(words), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
